// File: rtl/jk_counter_ctrl_if.sv
// Control/array bundle for jk_counter_ctrl: job handshake from top-level control plus J/K/Q to the flip-flop array.
// master = control side and array (drives requests and Q); slave = the sequencer.
interface jk_counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] ffq;
    logic [WIDTH-1:0] ffj;
    logic [WIDTH-1:0] ffk;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, load_val, limit, en, abort, ffq,
        input  ffj, ffk, busy, done
    );

    modport slave (
        input  start, dir, load_val, limit, en, abort, ffq,
        output ffj, ffk, busy, done
    );
endinterface

// File: rtl/jk_counter_ctrl.sv
// JK counter-array sequencer: load, count to limit, pulse done (N+3 edges, en-low stalls add one each, no queueing of start).
// Optional JK_CTRL_AUTO_RELOAD_EN: DONE returns to LOAD so the job repeats until abort or RST.
module jk_counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    jk_counter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic             dir_r;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] limit_r;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] up_tgl;
    logic [WIDTH-1:0] dn_tgl;
    logic [WIDTH-1:0] ffj_d;
    logic [WIDTH-1:0] ffk_d;
    logic             at_limit;

    assign at_limit = (bus.ffq == limit_r);

    // Ripple-carry/borrow toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic acc_up;
        logic acc_dn;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        up_tgl = '0;
        dn_tgl = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_tgl[i] = acc_up;
            dn_tgl[i] = acc_dn;
            acc_up    = acc_up & bus.ffq[i];
            acc_dn    = acc_dn & ~bus.ffq[i];
        end
    end

    always_comb begin
        ffj_d = '0;
        ffk_d = '0;
        if (!RST && !bus.abort) begin
            case (state_q)
                LOAD: begin
                    ffj_d = load_r;
                    ffk_d = ~load_r;
                end
                RUN: begin
                    if (!at_limit && bus.en) begin
                        ffj_d = dir_r ? up_tgl : dn_tgl;
                        ffk_d = dir_r ? up_tgl : dn_tgl;
                    end
                end
                default: begin
                    ffj_d = '0;
                    ffk_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            dir_r   <= 1'b0;
            load_r  <= '0;
            limit_r <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.abort && bus.start) begin
                        dir_r   <= bus.dir;
                        load_r  <= bus.load_val;
                        limit_r <= bus.limit;
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_limit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
`ifdef JK_CTRL_AUTO_RELOAD_EN
                        state_q <= LOAD;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ffj  = ffj_d;
    assign bus.ffk  = ffk_d;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: behavioural JK array plus a per-cycle scoreboard of expected Q/busy/done.
module tb_jk_counter_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] q_arr;

    jk_counter_ctrl_if #(.WIDTH(8)) bus ();

    jk_counter_ctrl #(.WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK flip-flop array.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_arr <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                case ({bus.ffj[i], bus.ffk[i]})
                    2'b01:   q_arr[i] <= 1'b0;
                    2'b10:   q_arr[i] <= 1'b1;
                    2'b11:   q_arr[i] <= ~q_arr[i];
                    default: q_arr[i] <= q_arr[i];
                endcase
            end
        end
    end
    assign bus.ffq = q_arr;

    int errors = 0;
    int checks = 0;

    logic [7:0] cur;
    logic [7:0] exp_q[$];
    logic       exp_busy[$];
    logic       exp_done[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] q, input logic b, input logic d);
        exp_q.push_back(q);
        exp_busy.push_back(b);
        exp_done.push_back(d);
    endtask

    // Builds the expected per-edge trace of one job from a plain arithmetic counter,
    // then drives it and compares every cycle. ab_t/junk_t < 0 disable abort/junk start.
    task automatic run_job(input string nm, input logic d, input logic [7:0] ld,
                           input logic [7:0] lim, input int st_at, input int st_len,
                           input int ab_t, input int junk_t, input int exp_lat);
        logic [7:0] q;
        logic       en_s[$];
        logic       ab_s[$];
        logic       jk_s[$];
        int         t;
        int         lat;
        bit         fin;

        push_exp(cur, 1'b1, 1'b0);
        en_s.push_back(1'b1); ab_s.push_back(1'b0); jk_s.push_back(1'b0);
        q = ld;
        push_exp(q, 1'b1, 1'b0);
        t = 1;
        fin = 0;
        while (!fin) begin
            logic e;
            logic a;
            e = !((t - 1) >= st_at && (t - 1) < st_at + st_len);
            a = (t == ab_t);
            en_s.push_back(e); ab_s.push_back(a); jk_s.push_back(t == junk_t);
            if (a) begin
                push_exp(q, 1'b0, 1'b0);
                fin = 1;
            end else if (q == lim) begin
                push_exp(q, 1'b1, 1'b1);
                push_exp(q, 1'b0, 1'b0);
                fin = 1;
            end else begin
                if (e) q = d ? q + 8'd1 : q - 8'd1;
                push_exp(q, 1'b1, 1'b0);
            end
            t++;
        end
        repeat (2) push_exp(q, 1'b0, 1'b0);
        cur = q;

        bus.dir      = d;
        bus.load_val = ld;
        bus.limit    = lim;
        bus.start    = 1'b1;
        bus.en       = 1'b1;
        bus.abort    = 1'b0;
        lat = 0;
        t   = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            chk({nm, "_q"},    {24'd0, q_arr},    {24'd0, exp_q.pop_front()});
            chk({nm, "_busy"}, {31'd0, bus.busy}, {31'd0, exp_busy.pop_front()});
            chk({nm, "_done"}, {31'd0, bus.done}, {31'd0, exp_done.pop_front()});
            if (bus.done === 1'b1 && lat == 0) lat = t + 1;
            bus.start = 1'b0;
            bus.en    = 1'b1;
            bus.abort = 1'b0;
            if (en_s.size() > 0) begin
                bus.en    = en_s.pop_front();
                bus.abort = ab_s.pop_front();
                if (jk_s.pop_front()) begin
                    bus.start    = 1'b1;
                    bus.dir      = ~d;
                    bus.load_val = 8'hAA;
                    bus.limit    = 8'h55;
                end
            end
            t++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk({nm, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dir      = 1'b1;
        bus.load_val = 8'h05;
        bus.limit    = 8'h08;
        bus.en       = 1'b1;
        bus.abort    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ffj",  {24'd0, bus.ffj},  32'd0);
        chk("rst_ffk",  {24'd0, bus.ffk},  32'd0);
        chk("rst_q",    {24'd0, q_arr},    32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        cur = 8'h00;

        // name, dir, load, limit, stall_at, stall_len, abort_t, junk_start_t, done latency
        run_job("up",    1'b1, 8'h05, 8'h08, 99, 0, -1,  3, 6);
        run_job("wrapu", 1'b1, 8'hFE, 8'h01, 99, 0, -1, -1, 6);
        run_job("wrapd", 1'b0, 8'h01, 8'hFE, 99, 0, -1, -1, 6);
        run_job("stall", 1'b1, 8'h10, 8'h12,  1, 3, -1, -1, 8);
        run_job("zero",  1'b1, 8'h33, 8'h33, 99, 0, -1, -1, 3);
        run_job("abort", 1'b1, 8'h00, 8'h0A, 99, 0,  7, -1, 0);
        run_job("down",  1'b0, 8'h09, 8'h04, 99, 0, -1,  2, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
